// File: rtl/gigatron_video_out.sv
// gigatron_video_out
//   Re-times a Gigatron-style video source (active-low syncs plus low-depth
//   colour) into VGA-style outputs. It measures line length, tracks the raster
//   position, generates blanking, expands colour depth, and can dim odd lines.
//   Every output is registered one qualifying (ce_pix) edge after its inputs.
//
// Ports
//   clk_sys          sole clock
//   reset            synchronous, active-high, wins over ce_pix
//   ce_pix           pixel clock enable; all state holds while low
//   hsync_n/vsync_n  source syncs, active-low
//   red/green/blue   source colour, IN_BITS per channel
//   scanlines        dim odd raster lines when high
//   VGA_R/G/B        expanded colour, OUT_BITS per channel, zero when blanked
//   VGA_HS/VGA_VS    registered syncs, inverted when SYNC_INVERT=1
//   VGA_HB/VGA_VB    horizontal/vertical blanking, 1 = blanked
//   locked           line length stable over consecutive lines
//   line_len         ce_pix count of the last complete line
module gigatron_video_out #(
  parameter int unsigned IN_BITS     = 2,
  parameter int unsigned OUT_BITS    = 8,
  parameter logic        SYNC_INVERT = 1'b1,
  parameter int unsigned H_START     = 48,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_START     = 33,
  parameter int unsigned V_ACTIVE    = 480
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ce_pix,
  input  logic                hsync_n,
  input  logic                vsync_n,
  input  logic [IN_BITS-1:0]  red,
  input  logic [IN_BITS-1:0]  green,
  input  logic [IN_BITS-1:0]  blue,
  input  logic                scanlines,
  output logic [OUT_BITS-1:0] VGA_R,
  output logic [OUT_BITS-1:0] VGA_G,
  output logic [OUT_BITS-1:0] VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                VGA_HB,
  output logic                VGA_VB,
  output logic                locked,
  output logic [10:0]         line_len
);

  // Output sync level while the source syncs are idle (high).
  localparam logic SYNC_IDLE = ~SYNC_INVERT;

  logic                hs_prev_q, vs_prev_q;
  logic                seen_q;
  logic [10:0]         hcnt_q, hcnt_d, hcnt_inc;
  logic [9:0]          vcnt_q, vcnt_d;
  logic                vpend_q, vpend_d;
  logic [1:0]          mcnt_q, mcnt_d;
  logic                locked_q, locked_d;
  logic [10:0]         len_q, len_d;
  logic                h_edge, v_edge, len_match;
  logic                h_act, v_act, blank, dim;
  logic [OUT_BITS-1:0] r_exp, g_exp, b_exp;
  logic [OUT_BITS-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
  logic                hs_d, vs_d, hs_q, vs_q, hb_q, vb_q;

  // Colour expansion: output bit i (from the MSB) takes input bit i mod IN_BITS
  // (from the MSB), i.e. the input pattern repeated and truncated.
  for (genvar i = 0; i < OUT_BITS; i++) begin : g_rep
    assign r_exp[OUT_BITS-1-i] = red  [IN_BITS-1-(i % IN_BITS)];
    assign g_exp[OUT_BITS-1-i] = green[IN_BITS-1-(i % IN_BITS)];
    assign b_exp[OUT_BITS-1-i] = blue [IN_BITS-1-(i % IN_BITS)];
  end

  always_comb begin
    h_edge   = ~hsync_n & hs_prev_q;
    v_edge   = ~vsync_n & vs_prev_q;

    hcnt_inc = (hcnt_q == '1) ? hcnt_q : hcnt_q + 11'd1;
    hcnt_d   = h_edge ? '0 : hcnt_inc;

    // Line measurement; the first edge after reset only starts the count,
    // since the line it closes was not measured from its beginning.
    len_d     = len_q;
    mcnt_d    = mcnt_q;
    locked_d  = locked_q;
    len_match = 1'b0;
    if (h_edge && seen_q) begin
      len_d     = hcnt_inc;
      // A saturated line never matches, even against an earlier saturated one.
      len_match = (hcnt_inc == len_q) && (hcnt_q != '1);
      if (len_match) begin
        mcnt_d = (mcnt_q == 2'd3) ? mcnt_q : mcnt_q + 2'd1;
        if (mcnt_d == 2'd3) locked_d = 1'b1;
      end else begin
        mcnt_d   = '0;
        locked_d = 1'b0;
      end
    end

    // A vsync edge arms vpend; the next hsync edge (or the same one) restarts
    // the line count at 0.
    vcnt_d  = vcnt_q;
    vpend_d = vpend_q | v_edge;
    if (h_edge) begin
      if (vpend_q | v_edge) begin
        vcnt_d  = '0;
        vpend_d = 1'b0;
      end else begin
        vcnt_d = (vcnt_q == '1) ? vcnt_q : vcnt_q + 10'd1;
      end
    end

    h_act = (32'(hcnt_d) >= H_START) && (32'(hcnt_d) < H_START + H_ACTIVE);
    v_act = (32'(vcnt_d) >= V_START) && (32'(vcnt_d) < V_START + V_ACTIVE);
    blank = ~(h_act & v_act);
    dim   = scanlines & vcnt_d[0];

    r_d = blank ? '0 : (dim ? (r_exp >> 1) : r_exp);
    g_d = blank ? '0 : (dim ? (g_exp >> 1) : g_exp);
    b_d = blank ? '0 : (dim ? (b_exp >> 1) : b_exp);

    hs_d = SYNC_INVERT ? ~hsync_n : hsync_n;
    vs_d = SYNC_INVERT ? ~vsync_n : vsync_n;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      seen_q    <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      vpend_q   <= 1'b0;
      mcnt_q    <= '0;
      locked_q  <= 1'b0;
      len_q     <= '0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= SYNC_IDLE;
      vs_q      <= SYNC_IDLE;
      hb_q      <= 1'b1;
      vb_q      <= 1'b1;
    end else if (ce_pix) begin
      hs_prev_q <= hsync_n;
      vs_prev_q <= vsync_n;
      seen_q    <= seen_q | h_edge;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      vpend_q   <= vpend_d;
      mcnt_q    <= mcnt_d;
      locked_q  <= locked_d;
      len_q     <= len_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hb_q      <= ~h_act;
      vb_q      <= ~v_act;
    end
  end

  assign VGA_R    = r_q;
  assign VGA_G    = g_q;
  assign VGA_B    = b_q;
  assign VGA_HS   = hs_q;
  assign VGA_VS   = vs_q;
  assign VGA_HB   = hb_q;
  assign VGA_VB   = vb_q;
  assign locked   = locked_q;
  assign line_len = len_q;

endmodule

// File: tb/tb_gigatron_video_out.sv
// Scoreboard bench for gigatron_video_out. Two instances share the sync stream:
// u_dut uses the defaults (2->8 bit, inverted syncs), u_dut3 expands 3->8 with
// non-inverted syncs. The reference model tracks pixel position, line number
// and a history of measured line lengths, and derives lock from that history.
module tb_gigatron_video_out;

  logic       clk_sys = 1'b0;
  logic       reset, ce_pix, hsync_n, vsync_n, scanlines, scan3;
  logic [1:0] red, green, blue;
  logic [2:0] red3, green3, blue3;

  logic [7:0]  r1, g1, b1, r3, g3, b3;
  logic        hs1, vs1, hb1, vb1, lk1, hs3, vs3, hb3, vb3, lk3;
  logic [10:0] len1, len3;

  always #5 clk_sys = ~clk_sys;

  gigatron_video_out u_dut (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .hsync_n(hsync_n), .vsync_n(vsync_n),
    .red(red), .green(green), .blue(blue), .scanlines(scanlines),
    .VGA_R(r1), .VGA_G(g1), .VGA_B(b1),
    .VGA_HS(hs1), .VGA_VS(vs1), .VGA_HB(hb1), .VGA_VB(vb1),
    .locked(lk1), .line_len(len1)
  );

  gigatron_video_out #(
    .IN_BITS(3), .OUT_BITS(8), .SYNC_INVERT(1'b0)
  ) u_dut3 (
    .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
    .hsync_n(hsync_n), .vsync_n(vsync_n),
    .red(red3), .green(green3), .blue(blue3), .scanlines(scan3),
    .VGA_R(r3), .VGA_G(g3), .VGA_B(b3),
    .VGA_HS(hs3), .VGA_VS(vs3), .VGA_HB(hb3), .VGA_VB(vb3),
    .locked(lk3), .line_len(len3)
  );

  typedef struct packed {
    logic [7:0]  r, g, b, r3, g3, b3;
    logic        hs, vs, hs3, vs3, hb, vb, lk;
    logic [10:0] len;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   started = 1'b0;

  // Reference model state.
  int m_pos, m_line, m_len;
  bit m_vpend, m_seen, m_hprev, m_vprev;
  int hist[$];
  bit hsat[$];

  function automatic logic [7:0] expand(input int unsigned v, input int unsigned nb);
    int unsigned rep  = 0;
    int unsigned bits = 0;
    while (bits < 8) begin
      rep  = (rep << nb) | v;
      bits = bits + nb;
    end
    return 8'(rep >> (bits - 8));
  endfunction

  function automatic logic [7:0] shade(input logic [7:0] x, input bit blank, input bit dim);
    if (blank) return 8'h00;
    return dim ? (x >> 1) : x;
  endfunction

  // Locked: the last four entries of the length history (initial 0 included)
  // agree and none of the last three measured lines hit saturation.
  function automatic bit model_locked();
    int n = hist.size();
    if (n < 4) return 1'b0;
    return (hist[n-1] == hist[n-2]) && (hist[n-2] == hist[n-3]) &&
           (hist[n-3] == hist[n-4]) && !hsat[n-1] && !hsat[n-2] && !hsat[n-3];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h at t=%0t", name, act, want, $time);
    end
  endtask

  // Computes the expected outputs after the coming edge, queues them, and
  // applies reset/ce for that edge.
  task automatic tick(input bit rst, input bit ce);
    exp_t e;
    bit he, ve, hact, vact, blank, dim1, dim3;
    if (rst) begin
      m_pos = 0; m_line = 0; m_len = 0;
      m_vpend = 1'b0; m_seen = 1'b0; m_hprev = 1'b1; m_vprev = 1'b1;
      hist.delete(); hsat.delete();
      hist.push_back(0); hsat.push_back(1'b0);
      e = '0;
      e.hb = 1'b1; e.vb = 1'b1;
      e.hs = 1'b0; e.vs = 1'b0; e.hs3 = 1'b1; e.vs3 = 1'b1;
    end else if (!ce) begin
      e = last_exp;
    end else begin
      he = !hsync_n && m_hprev;
      ve = !vsync_n && m_vprev;
      if (he) begin
        if (m_seen) begin
          m_len = (m_pos >= 2046) ? 2047 : m_pos + 1;
          hist.push_back(m_len);
          hsat.push_back(m_pos == 2047);
          while (hist.size() > 4) begin
            void'(hist.pop_front());
            void'(hsat.pop_front());
          end
        end
        m_seen = 1'b1;
        m_pos  = 0;
        if (m_vpend || ve) begin
          m_line  = 0;
          m_vpend = 1'b0;
        end else begin
          m_line = (m_line >= 1023) ? 1023 : m_line + 1;
        end
      end else begin
        m_pos = (m_pos >= 2047) ? 2047 : m_pos + 1;
        if (ve) m_vpend = 1'b1;
      end
      m_hprev = hsync_n;
      m_vprev = vsync_n;
      hact  = (m_pos >= 48) && (m_pos < 688);
      vact  = (m_line >= 33) && (m_line < 513);
      blank = !(hact && vact);
      dim1  = scanlines && (m_line % 2 == 1);
      dim3  = scan3 && (m_line % 2 == 1);
      e.r   = shade(expand(red, 2), blank, dim1);
      e.g   = shade(expand(green, 2), blank, dim1);
      e.b   = shade(expand(blue, 2), blank, dim1);
      e.r3  = shade(expand(red3, 3), blank, dim3);
      e.g3  = shade(expand(green3, 3), blank, dim3);
      e.b3  = shade(expand(blue3, 3), blank, dim3);
      e.hs  = ~hsync_n; e.vs  = ~vsync_n;
      e.hs3 = hsync_n;  e.vs3 = vsync_n;
      e.hb  = !hact;    e.vb  = !vact;
      e.lk  = model_locked();
      e.len = 11'(m_len);
    end
    last_exp = e;
    sbq.push_back(e);
    reset  = rst;
    ce_pix = ce;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic rand_colours();
    red   = 2'($urandom); green  = 2'($urandom); blue  = 2'($urandom);
    red3  = 3'($urandom); green3 = 3'($urandom); blue3 = 3'($urandom);
    scanlines = 1'($urandom);
    scan3     = ($urandom_range(0, 7) != 0);
  endtask

  task automatic rand_inputs();
    rand_colours();
    hsync_n = 1'($urandom);
    vsync_n = 1'($urandom);
  endtask

  // vs_mode: 0 vsync high, 1 vsync low all line, 2 vsync falls mid-line.
  task automatic do_line(input int len, input int hs_low, input int vs_mode,
                         input int gap_at, input int rst_at);
    for (int p = 0; p < len; p++) begin
      if (p == rst_at) begin
        rand_inputs();
        tick(1'b1, 1'b1);
      end
      if (p == gap_at) begin
        repeat (10) begin
          rand_colours();
          tick(1'b0, 1'b0);
        end
      end
      while ($urandom_range(0, 15) == 0) begin
        rand_inputs();
        tick(1'b0, 1'b0);
      end
      hsync_n = (p < hs_low) ? 1'b0 : 1'b1;
      if (vs_mode == 1)                      vsync_n = 1'b0;
      else if (vs_mode == 2 && p >= len / 2) vsync_n = 1'b0;
      else                                   vsync_n = 1'b1;
      rand_colours();
      tick(1'b0, 1'b1);
    end
  endtask

  // Monitor: one expected record per clock, compared away from the edge.
  always @(negedge clk_sys) begin
    if (started) begin
      if (sbq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got empty queue, want a record at t=%0t", $time);
      end else begin
        mon_e = sbq.pop_front();
        chk("r",      32'(r1),   32'(mon_e.r));
        chk("g",      32'(g1),   32'(mon_e.g));
        chk("b",      32'(b1),   32'(mon_e.b));
        chk("hs",     32'(hs1),  32'(mon_e.hs));
        chk("vs",     32'(vs1),  32'(mon_e.vs));
        chk("hb",     32'(hb1),  32'(mon_e.hb));
        chk("vb",     32'(vb1),  32'(mon_e.vb));
        chk("locked", 32'(lk1),  32'(mon_e.lk));
        chk("len",    32'(len1), 32'(mon_e.len));
        chk("r3",     32'(r3),   32'(mon_e.r3));
        chk("g3",     32'(g3),   32'(mon_e.g3));
        chk("b3",     32'(b3),   32'(mon_e.b3));
        chk("hs3",    32'(hs3),  32'(mon_e.hs3));
        chk("vs3",    32'(vs3),  32'(mon_e.vs3));
        chk("hb3",    32'(hb3),  32'(mon_e.hb));
        chk("vb3",    32'(vb3),  32'(mon_e.vb));
        chk("locked3",32'(lk3),  32'(mon_e.lk));
        chk("len3",   32'(len3), 32'(mon_e.len));
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, want completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ce_pix = 1'b0;
    rand_inputs();
    started = 1'b1;
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);

    // Frame start with 800-pixel lines; lock after the 5th hsync edge.
    do_line(800, 96, 1, -1, -1);
    do_line(800, 96, 1, -1, -1);
    for (int i = 0; i < 5; i++) do_line(800, 96, 0, (i == 2) ? 300 : -1, -1);

    // One short line breaks lock; four matching lines restore it.
    do_line(799, 96, 0, -1, -1);
    for (int i = 0; i < 5; i++) do_line(800, 96, 0, -1, -1);

    // Saturating line counts as a mismatch.
    do_line(2100, 96, 0, -1, -1);
    for (int i = 0; i < 5; i++) do_line(800, 96, 0, -1, -1);

    // Reset mid-line (hsync high), then at a line start, then during hsync low.
    do_line(800, 96, 0, -1, 300);
    do_line(800, 96, 0, -1, 0);
    do_line(800, 96, 0, -1, 10);
    for (int i = 0; i < 5; i++) do_line(800, 96, 0, -1, -1);

    // Full short-line frame to reach the vertical active window edges.
    do_line(56, 8, 2, -1, -1);
    do_line(56, 8, 1, -1, -1);
    for (int i = 0; i < 523; i++) do_line(56, 8, 0, -1, -1);
    do_line(56, 8, 1, -1, -1);
    do_line(56, 8, 1, -1, -1);
    for (int i = 0; i < 10; i++) do_line(56, 8, 0, -1, -1);

    @(negedge clk_sys);
    #1;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
